toast_mem_loader: RTL and testbench

- Unified instruction/data memory for toast_top with a built-in program loader.
- Holds the core in reset, zero-fills the array, then accepts program words over a valid/ready stream and releases the core.
- Once running, serves the core's IMEM read port and DMEM read/write port with one-cycle registered latency.
- Sits directly beside the core: it drives IMEM_data and DMEM read data, and consumes IMEM_addr and the DMEM address, write data and byte-enable signals.

---
 rtl/toast_mem_loader.sv | 179 +++++++++++++++++
 tb/tb_toast_mem_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/toast_mem_loader.sv
// toast_mem_loader
// Unified instruction/data memory for toast_top with a built-in program loader.
// After load_start_i the core is held in reset while the whole array is
// zero-filled, then load_len_i words are accepted over a valid/ready stream
// starting at word 0, and finally the core is released. While running, the
// IMEM read port and the DMEM read/write port are served with one cycle of
// registered latency (read-first on a same-word collision).
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   load_start_i          begin clear-and-load (sampled in IDLE only)
//   load_len_i            program length in words, clamped to DEPTH_WORDS
//   load_valid_i/data_i   load stream word
//   load_ready_o          loader accepts a word
//   load_done_o           load complete, core running
//   core_resetn_o         active-low reset to the core
//   IMEM_addr_i/data_o    instruction byte address / word
//   DMEM_addr_i           data byte address
//   DMEM_wr_byte_en_i     per-byte write enables
//   DMEM_wr_data_i        write data
//   DMEM_rst_i            force next DMEM read data to 0
//   DMEM_rd_data_o        data read word
//   oob_o                 sticky out-of-range access flag
module toast_mem_loader #(
    parameter int ADDR_W      = 14,
    parameter int DEPTH_WORDS = 2**ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_start_i,
    input  logic [ADDR_W:0]   load_len_i,
    input  logic              load_valid_i,
    input  logic [31:0]       load_data_i,
    output logic              load_ready_o,
    output logic              load_done_o,
    output logic              core_resetn_o,
    input  logic [31:0]       IMEM_addr_i,
    output logic [31:0]       IMEM_data_o,
    input  logic [31:0]       DMEM_addr_i,
    input  logic [3:0]        DMEM_wr_byte_en_i,
    input  logic [31:0]       DMEM_wr_data_i,
    input  logic              DMEM_rst_i,
    output logic [31:0]       DMEM_rd_data_o,
    output logic              oob_o
);

    localparam int              MEM_WORDS = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(DEPTH_WORDS);
    localparam logic [ADDR_W:0] LAST_CLR  = (ADDR_W+1)'(DEPTH_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LOAD,
        ST_RUN
    } state_t;

    state_t          state_q, state_d;
    logic [ADDR_W:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] len_q, len_d;

    logic [31:0]       mem [MEM_WORDS];
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;

    logic              imem_oob, dmem_oob;
    logic [ADDR_W-1:0] imem_word, dmem_word;
    logic [31:0]       imem_data_q, dmem_data_q;
    logic              oob_q;

    // Byte-offset bits are architecturally ignored.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{IMEM_addr_i[1:0], DMEM_addr_i[1:0]};

    assign imem_oob  = |IMEM_addr_i[31:ADDR_W+2];
    assign dmem_oob  = |DMEM_addr_i[31:ADDR_W+2];
    assign imem_word = IMEM_addr_i[ADDR_W+1:2];
    assign dmem_word = DMEM_addr_i[ADDR_W+1:2];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
            wr_ptr_q  <= '0;
            len_q     <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            len_q     <= len_d;
        end
    end

    // Next-state logic also selects the single memory write port: the clear
    // sweep, the load stream and the core's DMEM writes are mutually
    // exclusive by state, so they share one byte-enabled port.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        wr_ptr_d  = wr_ptr_q;
        len_d     = len_q;
        mem_we    = '0;
        mem_waddr = '0;
        mem_wdata = '0;
        unique case (state_q)
            ST_IDLE: begin
                clr_cnt_d = '0;
                wr_ptr_d  = '0;
                if (load_start_i) begin
                    len_d   = (load_len_i > DEPTH_L) ? DEPTH_L : load_len_i;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                mem_we    = '1;
                mem_waddr = clr_cnt_q[ADDR_W-1:0];
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_CLR) begin
                    state_d = (len_q == '0) ? ST_RUN : ST_LOAD;
                end
            end
            ST_LOAD: begin
                // load_ready_o is high throughout LOAD, so valid alone is a handshake.
                if (load_valid_i) begin
                    mem_we    = '1;
                    mem_waddr = wr_ptr_q[ADDR_W-1:0];
                    mem_wdata = load_data_i;
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                    if (wr_ptr_d == len_q) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                mem_we    = DMEM_wr_byte_en_i & {4{~dmem_oob}};
                mem_waddr = dmem_word;
                mem_wdata = DMEM_wr_data_i;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode the state register directly, so each asserts from the
    // first cycle of its state and never glitches with inputs.
    assign load_ready_o  = (state_q == ST_LOAD);
    assign load_done_o   = (state_q == ST_RUN);
    assign core_resetn_o = (state_q == ST_RUN);

    // Memory contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        for (int unsigned k = 0; k < 4; k++) begin
            if (mem_we[k]) begin
                mem[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            imem_data_q <= '0;
            dmem_data_q <= '0;
            oob_q       <= 1'b0;
        end else if (state_q == ST_RUN) begin
            imem_data_q <= imem_oob ? '0 : mem[imem_word];
            dmem_data_q <= (DMEM_rst_i || dmem_oob) ? '0 : mem[dmem_word];
            oob_q       <= oob_q | imem_oob | dmem_oob;
        end else begin
            imem_data_q <= '0;
            dmem_data_q <= '0;
        end
    end

    assign IMEM_data_o    = imem_data_q;
    assign DMEM_rd_data_o = dmem_data_q;
    assign oob_o          = oob_q;

endmodule

// File: tb/tb_toast_mem_loader.sv
// Testbench for toast_mem_loader (ADDR_W=4, DEPTH_WORDS=16).
// A behavioural model tracks the loader phase, a word array and the expected
// registered outputs; a compare process checks every output on each falling
// edge. Directed sequences add literal checks for latencies and data values.
module tb_toast_mem_loader;

    localparam int AW = 4;
    localparam int DW = 16;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        load_start_i;
    logic [AW:0] load_len_i;
    logic        load_valid_i;
    logic [31:0] load_data_i;
    logic        load_ready_o, load_done_o, core_resetn_o;
    logic [31:0] IMEM_addr_i, IMEM_data_o;
    logic [31:0] DMEM_addr_i, DMEM_wr_data_i, DMEM_rd_data_o;
    logic [3:0]  DMEM_wr_byte_en_i;
    logic        DMEM_rst_i;
    logic        oob_o;

    toast_mem_loader #(.ADDR_W(AW), .DEPTH_WORDS(DW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .load_start_i(load_start_i), .load_len_i(load_len_i),
        .load_valid_i(load_valid_i), .load_data_i(load_data_i),
        .load_ready_o(load_ready_o), .load_done_o(load_done_o),
        .core_resetn_o(core_resetn_o),
        .IMEM_addr_i(IMEM_addr_i), .IMEM_data_o(IMEM_data_o),
        .DMEM_addr_i(DMEM_addr_i), .DMEM_wr_byte_en_i(DMEM_wr_byte_en_i),
        .DMEM_wr_data_i(DMEM_wr_data_i), .DMEM_rst_i(DMEM_rst_i),
        .DMEM_rd_data_o(DMEM_rd_data_o), .oob_o(oob_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int P_IDLE = 0, P_CLEAR = 1, P_LOAD = 2, P_RUN = 3;
    int          phase = P_IDLE;
    int          mlen, cleared, got;
    logic [31:0] mmem [DW];
    logic [31:0] e_imem = '0, e_dmem = '0;
    logic        e_ready = 0, e_done = 0, e_oob = 0;
    bit          model_live = 0;

    always @(posedge clk_i) begin
        logic [31:0] w;
        int          iw, dw;
        bit          ioob, doob;
        e_imem = '0;
        e_dmem = '0;
        if (rst_i) begin
            phase = P_IDLE;
            e_oob = 0;
            model_live = 1;
        end else begin
            case (phase)
                P_IDLE: if (load_start_i) begin
                    mlen    = (int'(load_len_i) > DW) ? DW : int'(load_len_i);
                    cleared = 0;
                    got     = 0;
                    phase   = P_CLEAR;
                end
                P_CLEAR: begin
                    mmem[cleared] = '0;
                    cleared++;
                    if (cleared == DW) phase = (mlen == 0) ? P_RUN : P_LOAD;
                end
                P_LOAD: if (load_valid_i) begin
                    mmem[got] = load_data_i;
                    got++;
                    if (got == mlen) phase = P_RUN;
                end
                default: begin
                    iw   = int'(IMEM_addr_i[AW+1:2]);
                    dw   = int'(DMEM_addr_i[AW+1:2]);
                    ioob = (IMEM_addr_i >= 32'(DW * 4));
                    doob = (DMEM_addr_i >= 32'(DW * 4));
                    e_imem = ioob ? '0 : mmem[iw];
                    e_dmem = (doob || DMEM_rst_i) ? '0 : mmem[dw];
                    if (ioob || doob) e_oob = 1;
                    if (!doob) begin
                        w = mmem[dw];
                        for (int k = 0; k < 4; k++)
                            if (DMEM_wr_byte_en_i[k]) w[8*k +: 8] = DMEM_wr_data_i[8*k +: 8];
                        mmem[dw] = w;
                    end
                end
            endcase
        end
        e_ready = (phase == P_LOAD);
        e_done  = (phase == P_RUN);
    end

    always @(negedge clk_i) begin
        if (model_live) begin
            chk("m_ready", {31'b0, load_ready_o}, {31'b0, e_ready});
            chk("m_done", {31'b0, load_done_o}, {31'b0, e_done});
            chk("m_resetn", {31'b0, core_resetn_o}, {31'b0, e_done});
            chk("m_oob", {31'b0, oob_o}, {31'b0, e_oob});
            chk("m_imem", IMEM_data_o, e_imem);
            chk("m_dmem", DMEM_rd_data_o, e_dmem);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1; load_valid_i = 0; load_start_i = 0;
        @(posedge clk_i); #1;
        rst_i = 0;
    endtask

    task automatic start_load(input int len);
        @(negedge clk_i);
        load_start_i = 1; load_len_i = (AW+1)'(len);
        @(posedge clk_i); #1;
        load_start_i = 0;
    endtask

    // Counts edges after the start-sampling edge until ready appears.
    task automatic wait_ready(output int n);
        n = 0;
        while (!load_ready_o && n < 100) begin @(posedge clk_i); #1; n++; end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!load_done_o && n < 100) begin @(posedge clk_i); #1; n++; end
    endtask

    task automatic send(input logic [31:0] d, input int stall);
        repeat (stall) begin @(negedge clk_i); load_valid_i = 0; end
        @(negedge clk_i);
        load_valid_i = 1; load_data_i = d;
        @(posedge clk_i); #1;
    endtask

    task automatic run_cyc(input logic [31:0] ia, input logic [31:0] da, input logic [3:0] be,
                           input logic [31:0] wd, input logic drst);
        @(negedge clk_i);
        load_valid_i = 0;
        IMEM_addr_i = ia; DMEM_addr_i = da; DMEM_wr_byte_en_i = be;
        DMEM_wr_data_i = wd; DMEM_rst_i = drst;
        @(posedge clk_i); #1;
    endtask

    localparam logic [31:0] W0 = 32'h0000_0013, W1 = 32'h0010_0093, W2 = 32'h0000_0073;

    initial begin
        int n;
        rst_i = 1; load_start_i = 0; load_len_i = '0; load_valid_i = 0; load_data_i = '0;
        IMEM_addr_i = '0; DMEM_addr_i = '0; DMEM_wr_byte_en_i = '0; DMEM_wr_data_i = '0;
        DMEM_rst_i = 0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 0;
        chk("rst_resetn", {31'b0, core_resetn_o}, 32'd0);
        chk("rst_ready", {31'b0, load_ready_o}, 32'd0);
        chk("rst_imem", IMEM_data_o, 32'd0);

        // basic load
        start_load(3);
        wait_ready(n);
        chk("ready_latency", n, 32'd16);
        send(W0, 0);
        send(W1, 0);
        chk("done_early", {31'b0, load_done_o}, 32'd0);
        send(W2, 0);
        chk("done_after_last", {31'b0, load_done_o}, 32'd1);
        chk("resetn_after_last", {31'b0, core_resetn_o}, 32'd1);
        chk("ready_after_last", {31'b0, load_ready_o}, 32'd0);
        run_cyc(32'd8, 32'd0, 4'b0, '0, 0);
        chk("imem_8", IMEM_data_o, W2);

        // stalled stream
        do_reset();
        start_load(3);
        wait_ready(n);
        send(W0, 0);
        send(W1, 2);
        send(W2, 2);
        run_cyc(32'd0, 32'd0, 4'b0, '0, 0);  chk("stall_imem0", IMEM_data_o, W0);
        run_cyc(32'd4, 32'd0, 4'b0, '0, 0);  chk("stall_imem4", IMEM_data_o, W1);
        run_cyc(32'd8, 32'd0, 4'b0, '0, 0);  chk("stall_imem8", IMEM_data_o, W2);
        run_cyc(32'd12, 32'd0, 4'b0, '0, 0); chk("stall_imem12", IMEM_data_o, 32'd0);

        // byte writes to word 5, read-first on collision
        run_cyc(32'd0, 32'd20, 4'b1111, 32'h1122_3344, 0);
        run_cyc(32'd20, 32'd20, 4'b0010, 32'hAABB_CCDD, 0);
        chk("rdw_dmem_old", DMEM_rd_data_o, 32'h1122_3344);
        chk("rdw_imem_old", IMEM_data_o, 32'h1122_3344);
        run_cyc(32'd20, 32'd20, 4'b1001, 32'hAABB_CCDD, 0);
        chk("be_0010", DMEM_rd_data_o, 32'h1122_CC44);
        run_cyc(32'd20, 32'd20, 4'b0000, 32'h5555_5555, 0);
        chk("be_1001", DMEM_rd_data_o, 32'hAA22_CCDD);

        // DMEM_rst_i
        run_cyc(32'd0, 32'd0, 4'b0, '0, 1); chk("dmem_rst", DMEM_rd_data_o, 32'd0);
        run_cyc(32'd0, 32'd0, 4'b0, '0, 0); chk("dmem_rst_off", DMEM_rd_data_o, W0);

        // out of range
        chk("oob_clear", {31'b0, oob_o}, 32'd0);
        run_cyc(32'd0, 32'h40, 4'b1111, 32'hFFFF_FFFF, 0);
        chk("oob_set", {31'b0, oob_o}, 32'd1);
        chk("oob_dmem_rd", DMEM_rd_data_o, 32'd0);
        run_cyc(32'h44, 32'd0, 4'b0, '0, 0);
        chk("oob_imem_rd", IMEM_data_o, 32'd0);
        chk("oob_word0", DMEM_rd_data_o, W0);
        run_cyc(32'd0, 32'd0, 4'b0, '0, 0);
        chk("oob_sticky", {31'b0, oob_o}, 32'd1);

        // reset mid-load, then zero-length reload
        do_reset();
        start_load(3);
        wait_ready(n);
        send(W0, 0);
        do_reset();
        chk("abort_resetn", {31'b0, core_resetn_o}, 32'd0);
        chk("abort_ready", {31'b0, load_ready_o}, 32'd0);
        start_load(0);
        wait_done(n);
        chk("len0_latency", n, 32'd16);
        for (int i = 0; i < DW; i++) begin
            run_cyc(32'(4*i), 32'(4*i), 4'b0, '0, 0);
            chk("len0_imem", IMEM_data_o, 32'd0);
        end

        // oversized length clamps to the array depth
        do_reset();
        start_load(20);
        wait_ready(n);
        for (int i = 0; i < DW; i++) begin
            if (i == DW - 1) chk("clamp_not_done", {31'b0, load_done_o}, 32'd0);
            send(32'hC0DE_0000 + 32'(i), 0);
        end
        chk("clamp_done", {31'b0, load_done_o}, 32'd1);
        send(32'hDEAD_BEEF, 0);
        run_cyc(32'd60, 32'd0, 4'b0, '0, 0);
        chk("clamp_word15", IMEM_data_o, 32'hC0DE_000F);
        chk("clamp_word0", DMEM_rd_data_o, 32'hC0DE_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
